// File: rtl/mem_amo_responder.sv
// Memory-side responder for the core data-memory port: loads, fetches, stores,
// LR/SC and AMO read-modify-write against a single-port word SRAM (1-cycle read).
module mem_amo_responder #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_dir,
  input  logic [2:0]        req_size,
  input  logic [4:0]        req_amo,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  input  logic              rsv_clear,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] DIR_EXEC  = 2'b00;
  localparam logic [1:0] DIR_READ  = 2'b01;
  localparam logic [1:0] DIR_WRITE = 2'b10;
  localparam logic [1:0] DIR_AMO   = 2'b11;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_LR   = 5'b00010;
  localparam logic [4:0] AMO_SC   = 5'b00011;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_e;

  function automatic logic amo_known(input logic [4:0] op);
    case (op)
      AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
      AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: amo_known = 1'b1;
      default:                               amo_known = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] amo_calc(input logic [4:0] op, input logic [31:0] old,
                                           input logic [31:0] opnd);
    case (op)
      AMO_SWAP: amo_calc = opnd;
      AMO_ADD:  amo_calc = old + opnd;
      AMO_XOR:  amo_calc = old ^ opnd;
      AMO_OR:   amo_calc = old | opnd;
      AMO_AND:  amo_calc = old & opnd;
      AMO_MIN:  amo_calc = ($signed(old) < $signed(opnd)) ? old : opnd;
      AMO_MAX:  amo_calc = ($signed(old) > $signed(opnd)) ? old : opnd;
      AMO_MINU: amo_calc = (old < opnd) ? old : opnd;
      AMO_MAXU: amo_calc = (old > opnd) ? old : opnd;
      default:  amo_calc = old;
    endcase
  endfunction

  // Byte/half lanes are shifted down to bit 0, then sign- or zero-extended.
  function automatic logic [31:0] load_extract(input logic [2:0] size, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    load_extract = {{24{sh[7]}}, sh[7:0]};
      SZ_BU:   load_extract = {24'h000000, sh[7:0]};
      SZ_H:    load_extract = {{16{sh[15]}}, sh[15:0]};
      SZ_HU:   load_extract = {16'h0000, sh[15:0]};
      default: load_extract = sh;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] size, input logic [1:0] off);
    case (size[1:0])
      2'b00:   store_strb = 4'b0001 << off;
      2'b01:   store_strb = 4'b0011 << off;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] data);
    case (size[1:0])
      2'b00:   store_data = {4{data[7:0]}};
      2'b01:   store_data = {2{data[15:0]}};
      default: store_data = data;
    endcase
  endfunction

  state_e              state_r, state_next_s;
  logic                req_ready_r, rsp_valid_r, rsp_err_r;
  logic [31:0]         rsp_rdata_r;
  logic                mem_en_r, mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [3:0]          mem_wstrb_r;
  logic [31:0]         mem_wdata_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [1:0]          off_r;
  logic [2:0]          size_r;
  logic [1:0]          dir_r;
  logic [4:0]          amo_r;
  logic [31:0]         wdata_r;
  logic                rsv_valid_r;
  logic [ADDR_W-1:0]   rsv_addr_r;

  logic                accept_s, fault_s, misalign_s, size_ok_s, err_s;
  logic                sc_req_s, lr_req_s, rsv_match_s, rsv_kill_s, lr_cap_s;
  logic [ADDR_W-1:0]   req_word_s;
  logic                mem_en_s, mem_we_s, rsp_err_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [3:0]          mem_wstrb_s;
  logic [31:0]         mem_wdata_s, rsp_rdata_s;

  assign req_word_s  = req_addr[ADDR_W+1:2];
  assign accept_s    = req_valid && req_ready_r;
  assign fault_s     = |req_addr[31:ADDR_W+2];
  assign sc_req_s    = (req_dir == DIR_AMO) && (req_amo == AMO_SC);
  assign lr_req_s    = (req_dir == DIR_AMO) && (req_amo == AMO_LR);
  assign rsv_match_s = (rsv_addr_r == req_word_s);
  assign lr_cap_s    = (state_r == S_CAP) && (dir_r == DIR_AMO) && (amo_r == AMO_LR);

  // Request legality: size encoding, alignment, AMO/EXEC restrictions and range.
  always_comb begin
    size_ok_s  = 1'b0;
    misalign_s = 1'b0;
    case (req_size)
      SZ_B, SZ_BU: size_ok_s = 1'b1;
      SZ_H, SZ_HU: begin
        size_ok_s  = 1'b1;
        misalign_s = req_addr[0];
      end
      SZ_W: begin
        size_ok_s  = 1'b1;
        misalign_s = |req_addr[1:0];
      end
      default: size_ok_s = 1'b0;
    endcase
    err_s = fault_s || !size_ok_s || misalign_s
         || ((req_dir == DIR_AMO) && ((req_size != SZ_W) || !amo_known(req_amo)))
         || ((req_dir == DIR_EXEC) && (req_size != SZ_W));
  end

  // A store or RMW to the reserved word, or any SC, drops the reservation.
  always_comb begin
    if (accept_s && !err_s) begin
      rsv_kill_s = sc_req_s
                || (rsv_match_s && ((req_dir == DIR_WRITE) || ((req_dir == DIR_AMO) && !lr_req_s)));
    end else begin
      rsv_kill_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state plus next values of the registered SRAM and response outputs.
  always_comb begin
    state_next_s = state_r;
    mem_en_s     = 1'b0;
    mem_we_s     = 1'b0;
    mem_addr_s   = '0;
    mem_wstrb_s  = 4'b0000;
    mem_wdata_s  = 32'h0000_0000;
    rsp_rdata_s  = rsp_rdata_r;
    rsp_err_s    = rsp_err_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          rsp_rdata_s = 32'h0000_0000;
          rsp_err_s   = err_s;
          if (err_s) begin
            state_next_s = S_RESP;
          end else if (req_dir == DIR_WRITE) begin
            state_next_s = S_WR;
            mem_en_s     = 1'b1;
            mem_we_s     = 1'b1;
            mem_addr_s   = req_word_s;
            mem_wstrb_s  = store_strb(req_size, req_addr[1:0]);
            mem_wdata_s  = store_data(req_size, req_wdata);
          end else if (sc_req_s) begin
            if (rsv_valid_r && rsv_match_s) begin
              state_next_s = S_WR;
              mem_en_s     = 1'b1;
              mem_we_s     = 1'b1;
              mem_addr_s   = req_word_s;
              mem_wstrb_s  = 4'b1111;
              mem_wdata_s  = req_wdata;
            end else begin
              state_next_s = S_RESP;
              rsp_rdata_s  = 32'h0000_0001;
            end
          end else begin
            state_next_s = S_RD;
            mem_en_s     = 1'b1;
            mem_addr_s   = req_word_s;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RD: begin
        state_next_s = S_CAP;
      end
      S_CAP: begin
        if ((dir_r == DIR_AMO) && (amo_r != AMO_LR)) begin
          state_next_s = S_WR;
          mem_en_s     = 1'b1;
          mem_we_s     = 1'b1;
          mem_addr_s   = addr_r;
          mem_wstrb_s  = 4'b1111;
          mem_wdata_s  = amo_calc(amo_r, mem_rdata, wdata_r);
          rsp_rdata_s  = mem_rdata;
        end else begin
          state_next_s = S_RESP;
          rsp_rdata_s  = load_extract(size_r, off_r, mem_rdata);
        end
      end
      S_WR: begin
        state_next_s = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_next_s = S_IDLE;
          rsp_rdata_s  = 32'h0000_0000;
          rsp_err_s    = 1'b0;
        end else begin
          state_next_s = S_RESP;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Registered outputs; a reset drops any pending write or response.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wstrb_r <= 4'b0000;
      mem_wdata_r <= 32'h0000_0000;
    end else begin
      req_ready_r <= (state_next_s == S_IDLE);
      rsp_valid_r <= (state_next_s == S_RESP);
      rsp_err_r   <= rsp_err_s;
      rsp_rdata_r <= rsp_rdata_s;
      mem_en_r    <= mem_en_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wstrb_r <= mem_wstrb_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  // Request capture on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= '0;
      off_r   <= 2'b00;
      size_r  <= 3'b000;
      dir_r   <= 2'b00;
      amo_r   <= 5'b00000;
      wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      addr_r  <= req_word_s;
      off_r   <= req_addr[1:0];
      size_r  <= req_size;
      dir_r   <= req_dir;
      amo_r   <= req_amo;
      wdata_r <= req_wdata;
    end
  end

  // Reservation: kills (including rsv_clear) win over an LR set in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsv_valid_r <= 1'b0;
      rsv_addr_r  <= '0;
    end else if (rsv_clear || rsv_kill_s) begin
      rsv_valid_r <= 1'b0;
    end else if (lr_cap_s) begin
      rsv_valid_r <= 1'b1;
      rsv_addr_r  <= addr_r;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wstrb = mem_wstrb_r;
  assign mem_wdata = mem_wdata_r;

endmodule
